// File: rtl/flit_sched_pkg.sv
// Shared types and width helpers for the flit request scheduler.
package flit_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2
  } sched_state_e;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned idx_width(input int unsigned flits);
    return (flits <= 1) ? 1 : $clog2(flits);
  endfunction

endpackage

// File: rtl/flit_request_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module rr_arbiter
  import flit_sched_pkg::*;
#(
  parameter  int unsigned NUM_NODES = 4,
  localparam int unsigned NODE_W    = id_width(NUM_NODES)
) (
  input  logic [NUM_NODES-1:0] i_req,
  input  logic [NODE_W-1:0]    i_ptr,
  output logic                 o_valid,
  output logic [NODE_W-1:0]    o_id
);

  always_comb begin
    logic [NODE_W-1:0] w_idx;
    w_idx   = '0;
    o_valid = 1'b0;
    o_id    = '0;
    for (int unsigned i = 0; i < NUM_NODES; i++) begin
      w_idx = NODE_W'((32'(i_ptr) + i) % NUM_NODES);
      if (!o_valid && i_req[w_idx]) begin
        o_valid = 1'b1;
        o_id    = w_idx;
      end
    end
  end

endmodule

// File: rtl/flit_request_scheduler.sv
// Per-node flit counting, completed-request tracking and round-robin grant of a
// single merge/split engine, with overrun and BUSY-timeout reporting.
module flit_request_scheduler
  import flit_sched_pkg::*;
#(
  parameter  int unsigned NUM_NODES     = 4,
  parameter  int unsigned FLITS_TO_SEND = 3,
  parameter  int unsigned TIMEOUT       = 1024,
  localparam int unsigned NODE_W        = id_width(NUM_NODES),
  localparam int unsigned IDX_W         = idx_width(FLITS_TO_SEND)
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 flit_valid,
  input  logic [NODE_W-1:0]    flit_src,
  output logic                 grant_valid,
  output logic [NODE_W-1:0]    grant_id,
  input  logic                 grant_ack,
  input  logic                 done,
  output logic                 busy,
  output logic [NUM_NODES-1:0] pending,
  output logic [IDX_W-1:0]     flit_index,
  output logic [NUM_NODES-1:0] overrun_err,
  output logic                 timeout_err
);

  localparam int unsigned          TMR_W    = id_width(TIMEOUT);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(FLITS_TO_SEND - 1);
  localparam logic [TMR_W-1:0]     TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [NODE_W-1:0]    LAST_ID  = NODE_W'(NUM_NODES - 1);

  sched_state_e         r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_cnt [NUM_NODES];
  logic [NUM_NODES-1:0] r_pending, r_overrun;
  logic [NUM_NODES-1:0] w_complete, w_clear;
  logic [NODE_W-1:0]    r_grant_id, w_grant_id_nxt;
  logic [NODE_W-1:0]    r_ptr, w_ptr_nxt;
  logic [NODE_W-1:0]    w_arb_id;
  logic                 w_arb_valid;
  logic [TMR_W-1:0]     r_timer, w_timer_nxt;
  logic                 r_grant_valid, r_busy, r_timeout, w_timeout_nxt;

  rr_arbiter #(.NUM_NODES(NUM_NODES)) u_rr_arbiter (
    .i_req   (r_pending),
    .i_ptr   (r_ptr),
    .o_valid (w_arb_valid),
    .o_id    (w_arb_id)
  );

  assign flit_index = r_cnt[flit_src];

  // Completion and grant-acceptance events per node
  always_comb begin
    w_complete = '0;
    w_clear    = '0;
    for (int unsigned i = 0; i < NUM_NODES; i++) begin
      w_complete[i] = flit_valid && (flit_src == NODE_W'(i)) && (r_cnt[i] == LAST_IDX);
      w_clear[i]    = (r_state == ST_GRANT) && grant_ack && (r_grant_id == NODE_W'(i));
    end
  end

  // Counters never stall; a completion landing on the ack cycle re-arms pending
  always_ff @(posedge clk) begin
    if (res) begin
      for (int unsigned i = 0; i < NUM_NODES; i++) r_cnt[i] <= '0;
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      if (flit_valid) begin
        r_cnt[flit_src] <= (r_cnt[flit_src] == LAST_IDX) ? '0 : r_cnt[flit_src] + IDX_W'(1);
      end
      r_pending <= (r_pending & ~w_clear) | w_complete;
      r_overrun <= r_overrun | (w_complete & r_pending & ~w_clear);
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_state       <= ST_IDLE;
      r_grant_id    <= '0;
      r_ptr         <= '0;
      r_timer       <= '0;
      r_grant_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_grant_id    <= w_grant_id_nxt;
      r_ptr         <= w_ptr_nxt;
      r_timer       <= w_timer_nxt;
      r_grant_valid <= (w_state_nxt == ST_GRANT);
      r_busy        <= (w_state_nxt != ST_IDLE);
      r_timeout     <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_id_nxt = r_grant_id;
    w_ptr_nxt      = r_ptr;
    w_timer_nxt    = r_timer;
    w_timeout_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_timer_nxt = '0;
        if (w_arb_valid) begin
          w_grant_id_nxt = w_arb_id;
          w_state_nxt    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (grant_ack) begin
          w_ptr_nxt   = (r_grant_id == LAST_ID) ? '0 : r_grant_id + NODE_W'(1);
          w_timer_nxt = '0;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (done) begin
          w_state_nxt = ST_IDLE;
        end else if (r_timer == TMR_LAST) begin
          w_timeout_nxt = 1'b1;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign grant_valid = r_grant_valid;
  assign grant_id    = r_grant_id;
  assign busy        = r_busy;
  assign pending     = r_pending;
  assign overrun_err = r_overrun;
  assign timeout_err = r_timeout;

endmodule

// File: tb/tb_flit_request_scheduler.sv
// Scoreboard bench: expected grant order queued as requests complete, checked on grant.
module tb_flit_request_scheduler;

  localparam int unsigned NN  = 4;
  localparam int unsigned FTS = 3;
  localparam int unsigned TO  = 16;

  logic          clk = 1'b0;
  logic          res = 1'b1;
  logic          flit_valid = 1'b0;
  logic [1:0]    flit_src = '0;
  logic          grant_valid;
  logic [1:0]    grant_id;
  logic          grant_ack = 1'b0;
  logic          done = 1'b0;
  logic          busy;
  logic [NN-1:0] pending;
  logic [1:0]    flit_index;
  logic [NN-1:0] overrun_err;
  logic          timeout_err;

  int n_cmp = 0;
  int n_err = 0;
  int sb[$];

  flit_request_scheduler #(.NUM_NODES(NN), .FLITS_TO_SEND(FTS), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .res         (res),
    .flit_valid  (flit_valid),
    .flit_src    (flit_src),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .grant_ack   (grant_ack),
    .done        (done),
    .busy        (busy),
    .pending     (pending),
    .flit_index  (flit_index),
    .overrun_err (overrun_err),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_flit(input int src, input int exp_idx);
    flit_valid = 1'b1;
    flit_src   = 2'(src);
    #1;
    chk("flit_index", 32'(flit_index), 32'(exp_idx));
    step();
    flit_valid = 1'b0;
  endtask

  task automatic full_request(input int src);
    for (int k = 0; k < int'(FTS); k++) send_flit(src, k);
  endtask

  task automatic wait_grant();
    int n = 0;
    int exp_id;
    while (!grant_valid && n < 50) begin
      step();
      n++;
    end
    chk("grant_seen", 32'(grant_valid), 32'd1);
    chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
    if (grant_valid && sb.size() != 0) begin
      exp_id = sb.pop_front();
      chk("grant_id", 32'(grant_id), 32'(exp_id));
    end
  endtask

  task automatic do_ack();
    grant_ack = 1'b1;
    step();
    grant_ack = 1'b0;
    chk("busy_after_ack", 32'(busy), 32'd1);
    chk("gv_after_ack", 32'(grant_valid), 32'd0);
  endtask

  task automatic do_done();
    step();
    step();
    done = 1'b1;
    step();
    done = 1'b0;
    chk("idle_after_done", 32'(busy), 32'd0);
  endtask

  task automatic serve();
    wait_grant();
    do_ack();
    do_done();
  endtask

  task automatic do_reset();
    res = 1'b1;
    step();
    step();
    res = 1'b0;
  endtask

  initial begin
    int n;
    step();
    do_reset();
    chk("rst_gv", 32'(grant_valid), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_overrun", 32'(overrun_err), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);

    // 1: single request from node 2
    full_request(2);
    sb.push_back(2);
    chk("t1_pending", 32'(pending), 32'b0100);
    chk("t1_gv_early", 32'(grant_valid), 32'd0);
    step();
    chk("t1_gv", 32'(grant_valid), 32'd1);
    serve();
    chk("t1_pending_clr", 32'(pending), 32'd0);

    // 2: nodes 0,1,3 from pointer 0
    do_reset();
    for (int k = 0; k < int'(FTS); k++) begin
      send_flit(0, k);
      send_flit(1, k);
      send_flit(3, k);
    end
    sb.push_back(0); sb.push_back(1); sb.push_back(3);
    serve();
    serve();
    serve();

    // 3: node 1 re-requests while busy, served after node 2
    full_request(1);
    full_request(2);
    sb.push_back(1);
    wait_grant();
    do_ack();
    full_request(1);
    sb.push_back(2); sb.push_back(1);
    chk("t3_pending", 32'(pending), 32'b0110);
    do_done();
    serve();
    serve();

    // 4: completion on the ack cycle keeps pending, no overrun
    full_request(0);
    sb.push_back(0);
    wait_grant();
    send_flit(0, 0);
    send_flit(0, 1);
    grant_ack = 1'b1;
    send_flit(0, 2);
    grant_ack = 1'b0;
    chk("t4_pending", 32'(pending), 32'b0001);
    chk("t4_overrun", 32'(overrun_err), 32'd0);
    chk("t4_busy", 32'(busy), 32'd1);
    sb.push_back(0);
    do_done();
    serve();

    // 5: overrun while pending; no timeout while waiting in GRANT
    full_request(0);
    sb.push_back(0);
    wait_grant();
    full_request(0);
    chk("t5_overrun", 32'(overrun_err), 32'b0001);
    chk("t5_pending", 32'(pending), 32'b0001);
    repeat (TO + 4) step();
    chk("t5_gv_hold", 32'(grant_valid), 32'd1);
    chk("t5_no_timeout", 32'(timeout_err), 32'd0);
    do_ack();
    do_done();
    chk("t5_overrun_sticky", 32'(overrun_err), 32'b0001);
    chk("t5_pending_clr", 32'(pending), 32'd0);

    // 6: BUSY timeout
    full_request(3);
    sb.push_back(3);
    wait_grant();
    do_ack();
    n = 0;
    while (!timeout_err && n < 100) begin
      step();
      n++;
    end
    chk("t6_timeout_cycles", 32'(n), 32'(TO));
    chk("t6_timeout_pulse", 32'(timeout_err), 32'd1);
    chk("t6_idle", 32'(busy), 32'd0);
    step();
    chk("t6_timeout_single", 32'(timeout_err), 32'd0);
    chk("t6_no_grant", 32'(grant_valid), 32'd0);

    // done while IDLE has no effect
    done = 1'b1;
    step();
    done = 1'b0;
    chk("idle_done_busy", 32'(busy), 32'd0);

    // reset in GRANT clears everything
    send_flit(2, 0);
    full_request(1);
    sb.push_back(1);
    wait_grant();
    res = 1'b1;
    step();
    chk("rg_gv", 32'(grant_valid), 32'd0);
    chk("rg_gid", 32'(grant_id), 32'd0);
    chk("rg_busy", 32'(busy), 32'd0);
    chk("rg_pending", 32'(pending), 32'd0);
    chk("rg_overrun", 32'(overrun_err), 32'd0);
    chk("rg_timeout", 32'(timeout_err), 32'd0);
    res = 1'b0;
    flit_src = 2'd2;
    #1;
    chk("rg_cnt2", 32'(flit_index), 32'd0);
    step();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
